instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the control unit in the LEGv8-style core.
- Holds the program counter and fetches 32-bit instruction words from instruction memory with a req/rdy handshake.
- Presents the instruction register and its decoded slices (OpCode[31:21], Cond[3:0]) to the control unit.
- Takes the control unit's PCSrc decision, plus the branch offset and register target, to compute the next PC.

Parameters:
- ADDR_W, 64, PC / instruction-memory address width
- RESET_PC, 0, PC value loaded on reset

Ports:
- CLK  in  1  system clock, rising edge
- RSTn  in  1  synchronous, active-low reset
- PCSrc  in  2  next-PC select: 00 PC+4, 01 PC+(BrOffset<<2), 10 RegTarget, 11 PC+4
- BrOffset  in  ADDR_W  sign-extended word offset from the SEU
- RegTarget  in  ADDR_W  register-file target for BR
- Advance  in  1  downstream consumes the current instruction this cycle
- IMemReq  out  1  fetch request
- IMemAddr  out  ADDR_W  fetch address; equals PC
- IMemRdy  in  1  IMemData valid this cycle
- IMemData  in  32  fetched instruction word
- PC  out  ADDR_W  address of the held instruction
- Instr  out  32  instruction register
- InstrValid  out  1  Instr is valid for the control unit
- OpCode  out  11  Instr[31:21]
- Cond  out  4  Instr[3:0]
- AlignFault  out  1  sticky misalignment fault (optional feature only)

Behaviour:
- Clock and reset: single clock CLK; reset RSTn is synchronous, active-low.
- All state updates happen on the rising CLK edge. With RSTn=0 sampled at an edge:
  - state=BOOT, PC=RESET_PC, Instr=0, AlignFault=0.
  - Outputs during and right after reset: IMemReq=0, InstrValid=0, OpCode=0, Cond=0.
- FSM states: BOOT, FETCH, ISSUE (plus HALT with the optional feature).
  - BOOT: IMemReq=0. Goes to FETCH next cycle unconditionally.
  - FETCH: IMemReq=1, IMemAddr=PC, InstrValid=0.
    - IMemRdy=1: Instr<=IMemData, go to ISSUE.
    - IMemRdy=0: stay in FETCH; request and address held stable.
    - IMemRdy arriving in the first FETCH cycle (zero wait) is legal. Minimum latency is BOOT→ISSUE in 2 cycles, then 1 fetch cycle per instruction.
  - ISSUE: IMemReq=0, InstrValid=1. Instr, PC, OpCode and Cond are held stable.
    - Advance=0: stay in ISSUE.
    - Advance=1: PC<=next PC, go to FETCH.
- Next-PC rules:
  - PCSrc, BrOffset and RegTarget are sampled only on the ISSUE&&Advance edge.
  - PC+4 and PC+(BrOffset<<2) use ADDR_W-bit modular arithmetic. Wrap from all-ones-minus-3 to 0 is silent.
  - BrOffset<<2 discards the top 2 bits.
  - PCSrc=11 behaves as 00.
- Advance outside ISSUE is ignored. IMemRdy outside FETCH is ignored; IMemData is not captured.
- Reset asserted mid-fetch (FETCH with IMemRdy pending) aborts the request. IMemReq drops in the cycle after the reset edge, and a late IMemRdy is ignored because the state is BOOT.
- OpCode and Cond are combinational slices of Instr.
- RegTarget misalignment (bits[1:0]≠0): the low two bits of the new PC are forced to 00.

Optional Feature:
- Macro: FETCH_ALIGN_CHK_EN.
- Defined:
  - An Advance with PCSrc=10 and RegTarget[1:0]≠0 sets AlignFault=1 (sticky until reset) and moves to HALT.
  - The PC is loaded with the unmodified RegTarget.
  - HALT: IMemReq=0, InstrValid=0. Advance is ignored and HALT is left only via reset.
- Undefined: HALT does not exist, low bits are silently cleared, and AlignFault is tied to 0.

Test Plan:
- Reset then zero-wait memory (IMemRdy=1 always, IMemData=32'hF2000000):
  - Cycle 2 after reset release: InstrValid=1, PC=0, OpCode=11'b11110010000, Cond=0.
- Sequential flow:
  - Stimulus: Advance=1 each ISSUE with PCSrc=00.
  - Expect: IMemAddr sequence 0,4,8,12, with exactly one FETCH cycle between ISSUE cycles.
- Wait states and stall:
  - Stimulus: IMemRdy delayed 3 cycles; Advance held 0 for 5 cycles in ISSUE.
  - Expect: IMemAddr stable during the wait; Instr/PC unchanged during the stall; no IMemReq.
- Branch:
  - PC=0x100, PCSrc=01, BrOffset=-2 → next IMemAddr=0xF8.
  - PC=0x100, PCSrc=10, RegTarget=0x2000 → next IMemAddr=0x2000.
  - PC=0x100, PCSrc=11 → 0x104.
- Wrap and reset:
  - PC=2^64-4, PCSrc=00 → PC=0.
  - RSTn=0 while FETCH has IMemReq=1 → next cycle IMemReq=0, PC=RESET_PC, InstrValid=0.
- Misalign (PCSrc=10, RegTarget=0x2002):
  - Macro undefined: PC=0x2000.
  - Macro defined: AlignFault=1, IMemReq stays 0 until reset.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : LEGv8 fetch stage. It holds the PC, fetches words over a
//               req/rdy handshake and presents Instr/OpCode/Cond to control.
//               Optional misaligned-BR trap: define FETCH_ALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [1:0]        PCSrc,
    input  logic [ADDR_W-1:0] BrOffset,
    input  logic [ADDR_W-1:0] RegTarget,
    input  logic              Advance,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic              IMemRdy,
    input  logic [31:0]       IMemData,
    output logic [ADDR_W-1:0] PC,
    output logic [31:0]       Instr,
    output logic              InstrValid,
    output logic [10:0]       OpCode,
    output logic [3:0]        Cond,
    output logic              AlignFault
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
`ifdef FETCH_ALIGN_CHK_EN
        ,
        S_HALT  = 2'd3
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] c_pc_step    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(3);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] w_next_pc;

`ifdef FETCH_ALIGN_CHK_EN
    logic fault_q, fault_d;
    logic w_misaligned_br;
`endif

    // Both adders wrap modulo 2^ADDR_W; the shift drops the offset's top bits.
    always_comb begin
        w_next_pc = pc_q + c_pc_step;
        case (PCSrc)
            2'b01:   w_next_pc = pc_q + (BrOffset << 2);
            2'b10:   w_next_pc = RegTarget & c_align_mask;
            default: w_next_pc = pc_q + c_pc_step;
        endcase
    end

`ifdef FETCH_ALIGN_CHK_EN
    assign w_misaligned_br = (PCSrc == 2'b10) && (RegTarget[1:0] != 2'b00);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_ALIGN_CHK_EN
        fault_d = fault_q;
`endif
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                if (IMemRdy) begin
                    instr_d = IMemData;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (Advance) begin
`ifdef FETCH_ALIGN_CHK_EN
                    if (w_misaligned_br) begin
                        pc_d    = RegTarget;
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = w_next_pc;
                        state_d = S_FETCH;
                    end
`else
                    pc_d    = w_next_pc;
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef FETCH_ALIGN_CHK_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
`ifdef FETCH_ALIGN_CHK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef FETCH_ALIGN_CHK_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign IMemReq    = (state_q == S_FETCH);
    assign IMemAddr   = pc_q;
    assign PC         = pc_q;
    assign Instr      = instr_q;
    assign InstrValid = (state_q == S_ISSUE);
    assign OpCode     = instr_q[31:21];
    assign Cond       = instr_q[3:0];
`ifdef FETCH_ALIGN_CHK_EN
    assign AlignFault = fault_q;
`else
    assign AlignFault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Scoreboard bench for instr_fetch_unit; stimulus queues the
//               expected fetch addresses/issued words, a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int AW = 64;

    logic          CLK       = 1'b0;
    logic          RSTn      = 1'b0;
    logic [1:0]    PCSrc     = 2'b00;
    logic [AW-1:0] BrOffset  = '0;
    logic [AW-1:0] RegTarget = '0;
    logic          Advance   = 1'b0;
    logic          IMemRdy   = 1'b0;
    logic [31:0]   IMemData  = '0;
    logic          IMemReq;
    logic [AW-1:0] IMemAddr;
    logic [AW-1:0] PC;
    logic [31:0]   Instr;
    logic          InstrValid;
    logic [10:0]   OpCode;
    logic [3:0]    Cond;
    logic          AlignFault;

    instr_fetch_unit #(.ADDR_W(AW), .RESET_PC('0)) dut (
        .CLK(CLK), .RSTn(RSTn), .PCSrc(PCSrc), .BrOffset(BrOffset),
        .RegTarget(RegTarget), .Advance(Advance), .IMemReq(IMemReq),
        .IMemAddr(IMemAddr), .IMemRdy(IMemRdy), .IMemData(IMemData),
        .PC(PC), .Instr(Instr), .InstrValid(InstrValid), .OpCode(OpCode),
        .Cond(Cond), .AlignFault(AlignFault)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   instr;
        int            fetch_len;
    } issue_t;

    int            checks   = 0;
    int            errors   = 0;
    int            wait_cfg = 0;
    int            req_cnt  = 0;
    logic [AW-1:0] exp_addr_q[$];
    issue_t        exp_issue_q[$];

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'hF200_0000 ^ a[31:0];
    endfunction

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory responder: ready after wait_cfg stalled request cycles.
    always @(negedge CLK) begin
        IMemData = mem_word(IMemAddr);
        if (IMemReq === 1'b1) begin
            IMemRdy = (req_cnt >= wait_cfg);
            req_cnt++;
        end else begin
            req_cnt = 0;
            IMemRdy = (wait_cfg == 0);
        end
    end

    // Monitor
    logic          prev_req   = 1'b0;
    logic          prev_valid = 1'b0;
    logic [AW-1:0] cur_addr   = '0;
    issue_t        cur_issue;
    int            fetch_len  = 0;

    always @(negedge CLK) begin
        if (IMemReq === 1'b1) begin
            if (!prev_req) begin
                fetch_len = 0;
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_fetch: addr %h, no fetch expected", IMemAddr);
                end else begin
                    cur_addr = exp_addr_q.pop_front();
                    check("fetch_addr", IMemAddr, cur_addr);
                end
            end else begin
                check("fetch_addr_stable", IMemAddr, cur_addr);
            end
            fetch_len++;
        end
        if (InstrValid === 1'b1) begin
            check("req_low_in_issue", 64'(IMemReq), 64'd0);
            if (!prev_valid) begin
                if (exp_issue_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: pc %h, no issue expected", PC);
                end else begin
                    cur_issue = exp_issue_q.pop_front();
                    check("issue_pc", PC, cur_issue.pc);
                    check("issue_instr", 64'(Instr), 64'(cur_issue.instr));
                    check("issue_opcode", 64'(OpCode), 64'(cur_issue.instr[31:21]));
                    check("issue_cond", 64'(Cond), 64'(cur_issue.instr[3:0]));
                    check("fetch_cycles", 64'(fetch_len), 64'(cur_issue.fetch_len));
                end
            end else begin
                check("pc_stable", PC, cur_issue.pc);
                check("instr_stable", 64'(Instr), 64'(cur_issue.instr));
            end
        end
        prev_req   = (IMemReq === 1'b1);
        prev_valid = (InstrValid === 1'b1);
    end

    task automatic wait_issue();
        int n = 0;
        while (InstrValid !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (InstrValid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL issue_timeout: InstrValid=%b after %0d cycles, expected 1", InstrValid, n);
        end
    endtask

    task automatic advance(input logic [1:0] src, input logic [AW-1:0] off,
                           input logic [AW-1:0] tgt, input logic [AW-1:0] next_pc,
                           input int wait_n);
        wait_issue();
        wait_cfg  = wait_n;
        PCSrc     = src;
        BrOffset  = off;
        RegTarget = tgt;
        Advance   = 1'b1;
        exp_addr_q.push_back(next_pc);
        exp_issue_q.push_back('{next_pc, mem_word(next_pc), wait_n + 1});
        @(posedge CLK); #1;
        Advance = 1'b0;
    endtask

    initial begin
        // Reset and zero-wait boot
        repeat (2) @(posedge CLK);
        #1;
        check("rst_req", 64'(IMemReq), 64'd0);
        check("rst_valid", 64'(InstrValid), 64'd0);
        check("rst_opcode", 64'(OpCode), 64'd0);
        check("rst_cond", 64'(Cond), 64'd0);
        check("rst_pc", PC, 64'd0);
        check("rst_fault", 64'(AlignFault), 64'd0);
        exp_addr_q.push_back(64'd0);
        exp_issue_q.push_back('{64'd0, 32'hF200_0000, 1});
        RSTn = 1'b1;
        @(posedge CLK); #1;
        check("boot_req", 64'(IMemReq), 64'd1);
        @(posedge CLK); #1;
        check("c2_valid", 64'(InstrValid), 64'd1);
        check("c2_pc", PC, 64'd0);
        check("c2_opcode", 64'(OpCode), 64'(11'b11110010000));
        check("c2_cond", 64'(Cond), 64'd0);

        // Sequential flow
        advance(2'b00, '0, '0, 64'd4, 0);
        advance(2'b00, '0, '0, 64'd8, 0);
        advance(2'b00, '0, '0, 64'd12, 0);

        // Stall in ISSUE, then a 3-cycle wait state with stray Advance
        wait_issue();
        repeat (5) @(negedge CLK);
        check("stall_valid", 64'(InstrValid), 64'd1);
        advance(2'b00, '0, '0, 64'd16, 3);
        PCSrc = 2'b10; RegTarget = 64'h3000; Advance = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        Advance = 1'b0;

        // Branches, register targets, PCSrc=11, wrap
        advance(2'b10, '0, 64'h100, 64'h100, 0);
        advance(2'b01, -64'sd2, '0, 64'hF8, 0);
        advance(2'b10, '0, 64'h100, 64'h100, 0);
        advance(2'b10, '0, 64'h2000, 64'h2000, 0);
        advance(2'b10, '0, 64'h100, 64'h100, 0);
        advance(2'b11, '0, '0, 64'h104, 0);
        advance(2'b10, '0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        advance(2'b00, '0, '0, 64'd0, 0);

        // Reset while a fetch is pending
        advance(2'b00, '0, '0, 64'd4, 5);
        @(negedge CLK);
        check("midfetch_req", 64'(IMemReq), 64'd1);
        RSTn = 1'b0;
        @(posedge CLK); #1;
        check("abort_req", 64'(IMemReq), 64'd0);
        check("abort_pc", PC, 64'd0);
        check("abort_valid", 64'(InstrValid), 64'd0);
        exp_issue_q.delete();
        exp_addr_q.delete();
        wait_cfg = 0;
        @(posedge CLK); #1;
        check("abort_req_hold", 64'(IMemReq), 64'd0);
        exp_addr_q.push_back(64'd0);
        exp_issue_q.push_back('{64'd0, 32'hF200_0000, 1});
        RSTn = 1'b1;

        // Misaligned register target
`ifdef FETCH_ALIGN_CHK_EN
        wait_issue();
        PCSrc = 2'b10; RegTarget = 64'h2002; Advance = 1'b1;
        @(posedge CLK); #1;
        check("halt_fault", 64'(AlignFault), 64'd1);
        check("halt_pc", PC, 64'h2002);
        check("halt_valid", 64'(InstrValid), 64'd0);
        PCSrc = 2'b00;
        for (int i = 0; i < 4; i++) begin
            check("halt_req", 64'(IMemReq), 64'd0);
            @(posedge CLK); #1;
        end
        Advance = 1'b0;
        check("halt_fault_sticky", 64'(AlignFault), 64'd1);
        RSTn = 1'b0;
        @(posedge CLK); #1;
        check("fault_cleared", 64'(AlignFault), 64'd0);
`else
        advance(2'b10, '0, 64'h2002, 64'h2000, 0);
        wait_issue();
        check("misalign_pc", PC, 64'h2000);
        check("misalign_fault", 64'(AlignFault), 64'd0);
`endif

        repeat (3) @(negedge CLK);
        check("addr_queue_empty", 64'(exp_addr_q.size()), 64'd0);
        check("issue_queue_empty", 64'(exp_issue_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
